lights_sequencer: RTL and testbench
===================================

Name: lights_sequencer

Overview:
Parametrised running-lights pattern generator for the board LED bank. A free-running divider produces step ticks at one of four run-time speeds. Each tick advances a WIDTH-bit pattern in one of four modes: rotate right, rotate left, ping-pong, or fill. The block drives the LED pins directly and also outputs a one-cycle step strobe for other lab modules.

Parameters:
WIDTH, 8, pattern/LED width; legal range 2..32
DIV_W, 27, divider counter width; legal range 4..32; the slowest tap is bit DIV_W-1

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous reset, active-low
mode  input  2  00 rotate right, 01 rotate left, 10 ping-pong, 11 fill
speed  input  2  tap select; tap bit = DIV_W-1-speed, so 0 is slowest and 3 is fastest
pause  input  1  1 = suppress pattern steps; the divider keeps running
dout  output  WIDTH  LED pattern
step  output  1  one-cycle pulse, high in the cycle dout shows a new value

Behaviour:
- Reset (arst_n low, asynchronous): divider=0, tap delay reg=0, speed_q=0, mode_q=00, dir=up, dout=1 (LSB set), step=0.
- Divider: increments every clk; wraps at 2^DIV_W-1 -> 0; never stopped by pause.
- tick (combinational) = div[tap] & ~tap_d & (speed==speed_q). tap_d samples div[tap] every cycle. speed_q samples speed every cycle, so the cycle in which speed changes never ticks. There is at most one lost tick per speed change and no spurious tick.
- adv = tick & ~pause. On adv, dout, dir, mode_q and step update at the same clk edge. Latency is one cycle from the tap rising to the new dout.
- Mode change: on an adv where mode != mode_q, dout loads the seed for the new mode and dir=up, instead of advancing; mode_q<=mode. Seed = 1 (LSB) for modes 00/01/10 and 0 for mode 11. Mode changes between ticks have no effect until the next adv.
- Rotate right (00): dout <= {dout[0], dout[WIDTH-1:1]}.
- Rotate left (01): dout <= {dout[WIDTH-2:0], dout[WIDTH-1]}.
- Ping-pong (10): if dir=up, shift left; if the result has MSB set, dir<=down. If dir=down, shift right; if the result has LSB set, dir<=up. There is no dwell at the ends, so the period is 2*WIDTH-2 steps.
- Fill (11): if dout is all-ones, dout<=0; otherwise dout <= {dout[WIDTH-2:0],1'b1}. The period is WIDTH+1 steps: 0, 1, 11, ..., all-ones, 0.
- Corrupt patterns (cannot occur from reset) are not recovered except by a mode change or reset.
- step: a register set to adv, so it is high exactly in the cycle following each adv edge. It is 0 while paused.
- pause held through a tick: that tick is dropped, not queued.
- Reset mid-sequence: immediate return to reset values. The first step after release follows the normal divider timing.

Optional Feature:
Macro LIGHTS_SEQ_FILL_EN.
- Defined: mode 11 = fill as above.
- Undefined: fill logic is not compiled; mode 11 behaves exactly as mode 00 (seed 1, rotate right).

Test Plan:
- DIV_W=4, WIDTH=8, speed=0, mode=00, release reset at count 0 -> first step when div goes 8->9, dout=8'h80; then steps every 16 cycles: 8'h40, 8'h20, ...; step high one cycle each time.
- speed=3, mode=01 -> steps every 2 cycles: 8'h02, 8'h04, ..., 8'h80, 8'h01 (wrap); change speed to 0 mid-run -> no step in the change cycle, then a 16-cycle spacing.
- WIDTH=4, mode=10 from reset -> mode change loads 4'b0001, then 0010, 0100, 1000, 0100, 0010, 0001, 0010 (period 6).
- WIDTH=4, mode=11 with the macro defined -> 0000, 0001, 0011, 0111, 1111, 0000. Without the macro -> the same sequence as rotate right.
- pause=1 across 3 ticks -> dout frozen, step stays 0; pause=0 -> resumes on the next tick with no burst.
- Assert arst_n low asynchronously mid-cycle during ping-pong down -> dout=1, dir=up, step=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/lights_sequencer.sv
// lights_sequencer
//   Running-lights pattern generator for the board LED bank. A free-running
//   divider supplies step ticks at one of four speeds. Each tick moves the
//   LED pattern one step in the selected mode: rotate right, rotate left,
//   ping-pong or fill.
//
// Ports
//   clk     system clock
//   arst_n  asynchronous reset, active-low
//   mode    00 rotate right, 01 rotate left, 10 ping-pong, 11 fill
//   speed   divider tap select, 0 = slowest, 3 = fastest
//   pause   1 holds the pattern; the divider keeps counting
//   dout    LED pattern, WIDTH bits
//   step    one-cycle strobe, high in the cycle dout shows a new value
//
// Build option
//   LIGHTS_SEQ_FILL_EN  when defined, mode 11 is the fill pattern. When it
//                       is undefined, mode 11 behaves exactly like rotate
//                       right (seed 1).
//
// Parameters
//   WIDTH  pattern width, 2..32
//   DIV_W  divider width, 4..32; the slowest tap is bit DIV_W-1

module lights_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [WIDTH-1:0] dout,
  output logic             step
);

  localparam int IDX_W = $clog2(DIV_W);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [DIV_W-1:0] div_q;
  logic             tap_d_q;
  logic [1:0]       speed_q;
  logic [1:0]       mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             step_q;

  logic [IDX_W-1:0] tapIdx;
  logic             tapBit;
  logic             tick;
  logic             adv;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shiftLeft;
  logic [WIDTH-1:0] shiftRight;

  // Tap moves one bit towards the LSB per speed step, so speed 3 is fastest.
  assign tapIdx = IDX_W'(DIV_W - 1) - IDX_W'(speed);
  assign tapBit = div_q[tapIdx];

  // A tick is a rising edge on the selected tap. The cycle in which speed
  // changes is masked, because tap_d_q still holds the old tap's value and
  // would otherwise fake an edge.
  assign tick = tapBit & ~tap_d_q & (speed == speed_q);
  assign adv  = tick & ~pause;

  assign shiftLeft  = {dout_q[WIDTH-2:0], 1'b0};
  assign shiftRight = {1'b0, dout_q[WIDTH-1:1]};

`ifdef LIGHTS_SEQ_FILL_EN
  assign seed = (mode == 2'b11) ? '0 : WIDTH'(1);
`else
  assign seed = WIDTH'(1);
`endif

  // Divider, tap edge detector, speed sample and pattern state registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_q   <= '0;
      tap_d_q <= 1'b0;
      speed_q <= 2'b00;
      mode_q  <= 2'b00;
      dir_q   <= DIR_UP;
      dout_q  <= WIDTH'(1);
      step_q  <= 1'b0;
    end else begin
      div_q   <= div_q + 1'b1;
      tap_d_q <= tapBit;
      speed_q <= speed;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      step_q  <= adv;
    end
  end

  // Next pattern. A mode change is only picked up on an advance, and that
  // advance loads the new mode's seed instead of moving the pattern.
  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (adv) begin
      mode_d = mode;
      if (mode != mode_q) begin
        dout_d = seed;
        dir_d  = DIR_UP;
      end else begin
        unique case (mode_q)
          2'b01: dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
          2'b10: begin
            // No dwell at the ends: direction flips on the step that lands
            // on the end bit.
            if (dir_q == DIR_UP) begin
              dout_d = shiftLeft;
              if (shiftLeft[WIDTH-1]) dir_d = DIR_DOWN;
            end else begin
              dout_d = shiftRight;
              if (shiftRight[0]) dir_d = DIR_UP;
            end
          end
`ifdef LIGHTS_SEQ_FILL_EN
          2'b11: begin
            if (&dout_q) dout_d = '0;
            else         dout_d = {dout_q[WIDTH-2:0], 1'b1};
          end
`endif
          default: dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
        endcase
      end
    end
  end

  assign dout = dout_q;
  assign step = step_q;

endmodule

// File: tb/tb_lights_sequencer.sv
// tb_lights_sequencer
//   Directed bench for lights_sequencer. Instance A is WIDTH=8, instance B
//   is WIDTH=4, both with DIV_W=4 so the tap periods are 16/8/4/2 cycles.
//   Outputs are sampled on the falling clock edge; the step spacing is
//   counted in falling edges since the previous observation point.

module tb_lights_sequencer;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [1:0] modeA = 2'b00, speedA = 2'b00;
  logic [1:0] modeB = 2'b00, speedB = 2'b00;
  logic       pauseA = 1'b0, pauseB = 1'b0;
  logic [7:0] doutA;
  logic [3:0] doutB;
  logic       stepA, stepB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lights_sequencer #(.WIDTH(8), .DIV_W(4)) dutA (
    .clk(clk), .arst_n(arst_n), .mode(modeA), .speed(speedA),
    .pause(pauseA), .dout(doutA), .step(stepA)
  );

  lights_sequencer #(.WIDTH(4), .DIV_W(4)) dutB (
    .clk(clk), .arst_n(arst_n), .mode(modeB), .speed(speedB),
    .pause(pauseB), .dout(doutB), .step(stepB)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reset both instances with the given settings, release on a falling edge
  // so the divider starts counting from 0 at the next rising edge.
  task automatic applyStimulus(input logic [1:0] mA, input logic [1:0] sA,
                               input logic [1:0] mB, input logic [1:0] sB);
    @(negedge clk);
    arst_n = 1'b0;
    modeA = mA; speedA = sA; pauseA = 1'b0;
    modeB = mB; speedB = sB; pauseB = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Count falling edges until the selected step strobe is seen, bounded.
  task automatic waitStep(input bit selB, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(selB ? stepB : stepA) && n < 40);
  endtask

  logic [7:0] rotLeftExp [8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h01};
  logic [3:0] pingExp [8]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`ifdef LIGHTS_SEQ_FILL_EN
  logic [3:0] fillExp [6]    = '{4'b0000, 4'b0001, 4'b0011,
                                 4'b0111, 4'b1111, 4'b0000};
`else
  logic [3:0] fillExp [6]    = '{4'b0001, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b1000};
`endif
  logic [7:0] rotRightExp [3] = '{8'h40, 8'h20, 8'h10};

  initial begin
    int n;

    // Rotate right at the slowest speed; first step as div goes 8->9.
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
    checkOutput("reset doutA", 32'(doutA), 32'h01);
    checkOutput("reset stepA", 32'(stepA), 32'h0);
    checkOutput("reset doutB", 32'(doutB), 32'h1);
    waitStep(1'b0, n);
    checkOutput("rr first gap", 32'(n), 32'd9);
    checkOutput("rr first dout", 32'(doutA), 32'h80);
    for (int i = 0; i < 3; i++) begin
      waitStep(1'b0, n);
      checkOutput("rr gap", 32'(n), 32'd16);
      checkOutput("rr dout", 32'(doutA), 32'(rotLeftExp[0] == 8'h02 ? rotRightExp[i] : 8'h00));
    end
    @(negedge clk);
    checkOutput("rr step one cycle", 32'(stepA), 32'h0);

    // Rotate left at the fastest speed; first advance loads the seed.
    applyStimulus(2'b01, 2'b11, 2'b00, 2'b00);
    waitStep(1'b0, n);
    checkOutput("rl seed gap", 32'(n), 32'd2);
    checkOutput("rl seed dout", 32'(doutA), 32'h01);
    for (int i = 0; i < 8; i++) begin
      waitStep(1'b0, n);
      checkOutput("rl gap", 32'(n), 32'd2);
      checkOutput("rl dout", 32'(doutA), 32'(rotLeftExp[i]));
    end

    // Slow down with div=2: next tap-3 rise is at div=8.
    speedA = 2'b00;
    waitStep(1'b0, n);
    checkOutput("slowdown gap", 32'(n), 32'd7);
    checkOutput("slowdown dout", 32'(doutA), 32'h02);

    // Speed up with div=3: bit0 is high and the old tap sample is 0, so the
    // change cycle must not tick; the next bit0 rise is two cycles later.
    repeat (10) @(negedge clk);
    speedA = 2'b11;
    waitStep(1'b0, n);
    checkOutput("speedup gap", 32'(n), 32'd3);
    checkOutput("speedup dout", 32'(doutA), 32'h04);
    waitStep(1'b0, n);
    checkOutput("speedup next gap", 32'(n), 32'd2);
    checkOutput("speedup next dout", 32'(doutA), 32'h08);

    // Ping-pong on the 4-bit instance.
    applyStimulus(2'b00, 2'b00, 2'b10, 2'b11);
    for (int i = 0; i < 8; i++) begin
      waitStep(1'b1, n);
      checkOutput("pp gap", 32'(n), 32'd2);
      checkOutput("pp dout", 32'(doutB), 32'(pingExp[i]));
    end

    // Mode 11 on the 4-bit instance (fill, or rotate right without fill).
    applyStimulus(2'b00, 2'b00, 2'b11, 2'b11);
    for (int i = 0; i < 6; i++) begin
      waitStep(1'b1, n);
      checkOutput("m11 gap", 32'(n), 32'd2);
      checkOutput("m11 dout", 32'(doutB), 32'(fillExp[i]));
    end

    // Pause across three ticks, then resume without a burst.
    applyStimulus(2'b00, 2'b11, 2'b00, 2'b00);
    waitStep(1'b0, n);
    checkOutput("pause pre1", 32'(doutA), 32'h80);
    waitStep(1'b0, n);
    checkOutput("pause pre2", 32'(doutA), 32'h40);
    pauseA = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("paused step", 32'(stepA), 32'h0);
    end
    checkOutput("paused dout", 32'(doutA), 32'h40);
    pauseA = 1'b0;
    waitStep(1'b0, n);
    checkOutput("resume gap", 32'(n), 32'd2);
    checkOutput("resume dout", 32'(doutA), 32'h20);
    waitStep(1'b0, n);
    checkOutput("resume next gap", 32'(n), 32'd2);
    checkOutput("resume next dout", 32'(doutA), 32'h10);

    // Asynchronous reset while ping-pong is heading down.
    applyStimulus(2'b00, 2'b00, 2'b10, 2'b11);
    for (int i = 0; i < 5; i++) waitStep(1'b1, n);
    checkOutput("pp before reset", 32'(doutB), 32'b0100);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("async doutB", 32'(doutB), 32'h1);
    checkOutput("async stepB", 32'(stepB), 32'h0);
    checkOutput("async doutA", 32'(doutA), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
